// File: rtl/csc_rd_if.sv
// csc_rd_if: descriptor (S_*) and element stream (e_*) handshake bundle
// for the csc_rd circulant-matrix reader. MAT_RANK must match the attached
// csc_rd instance.
interface csc_rd_if #(
    parameter int unsigned MAT_RANK = 256
);
    localparam int unsigned IDXW = $clog2(MAT_RANK);

    // descriptor side
    logic [4*IDXW-1:0] Scol_index;
    logic [31:0]       S_val_i0;
    logic [31:0]       S_val_i1;
    logic [31:0]       S_val_i2;
    logic [31:0]       S_val_i3;
    logic [31:0]       S_val_r0;
    logic [31:0]       S_val_r1;
    logic [31:0]       S_val_r2;
    logic [31:0]       S_val_r3;
    logic [2:0]        S_nnz;
    logic              S_vld;
    logic              S_rdy;

    // element stream side
    logic [IDXW-1:0]   e_row;
    logic [IDXW-1:0]   e_col;
    logic [31:0]       e_val_i;
    logic [31:0]       e_val_r;
    logic              e_last_row;
    logic              e_last;
    logic              e_vld;
    logic              e_rdy;

    // producer of descriptors / consumer of elements
    modport master (
        output Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
               S_val_r0, S_val_r1, S_val_r2, S_val_r3, S_nnz, S_vld, e_rdy,
        input  S_rdy, e_row, e_col, e_val_i, e_val_r, e_last_row, e_last, e_vld
    );

    // the reader itself
    modport slave (
        input  Scol_index, S_val_i0, S_val_i1, S_val_i2, S_val_i3,
               S_val_r0, S_val_r1, S_val_r2, S_val_r3, S_nnz, S_vld, e_rdy,
        output S_rdy, e_row, e_col, e_val_i, e_val_r, e_last_row, e_last, e_vld
    );
endinterface

// File: rtl/csc_rd.sv
// csc_rd: expands a circulant sparse-matrix descriptor (row-0 columns and
// up to four complex values) into a row-major element stream, nnz elements
// per row for MAT_RANK rows, with valid/ready flow control.
// Optional macro CSC_RD_HERM_EN: emit the Hermitian transpose instead
// (row/col swapped, imaginary part negated with saturation).
module csc_rd #(
    parameter int unsigned MAT_RANK = 256
) (
    input logic     clk,
    input logic     rst_n,
    csc_rd_if.slave bus
);
    localparam int unsigned IDXW = $clog2(MAT_RANK);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                 state_q, state_d;
    logic                   alive_q;
    logic [IDXW-1:0]        r_q, r_d;
    logic [1:0]             k_q, k_d;
    logic [2:0]             nnz_q, nnz_d;
    logic [3:0][IDXW-1:0]   col_q, col_d;
    logic [3:0][31:0]       vr_q, vr_d;
    logic [3:0][31:0]       vi_q, vi_d;

    logic                   s_rdy;
    logic                   last_row;
    logic                   last_mat;
    logic [IDXW-1:0]        s_row;
    logic [IDXW-1:0]        s_col;
    logic [31:0]            s_vi;

    function automatic logic [2:0] clamp_nnz(input logic [2:0] n);
        if (n < 3'd2) return 3'd2;
        if (n > 3'd4) return 3'd4;
        return n;
    endfunction

    // alive_q holds S_rdy low until the first clock edge after reset release
    assign s_rdy    = alive_q && (state_q == IDLE);
    assign last_row = (state_q == EMIT) && ({1'b0, k_q} == (nnz_q - 3'd1));
    assign last_mat = last_row && (r_q == '1);
    assign s_row    = r_q;
    assign s_col    = col_q[k_q] + r_q;
    assign s_vi     = vi_q[k_q];

    assign bus.S_rdy      = s_rdy;
    assign bus.e_vld      = (state_q == EMIT);
    assign bus.e_last_row = last_row;
    assign bus.e_last     = last_mat;
    assign bus.e_val_r    = vr_q[k_q];
`ifdef CSC_RD_HERM_EN
    assign bus.e_row      = s_col;
    assign bus.e_col      = s_row;
    assign bus.e_val_i    = (s_vi == 32'h8000_0000) ? 32'h7FFF_FFFF : (32'd0 - s_vi);
`else
    assign bus.e_row      = s_row;
    assign bus.e_col      = s_col;
    assign bus.e_val_i    = s_vi;
`endif

    // next-state: capture descriptor in IDLE, walk (r,k) on each accepted element
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        k_d     = k_q;
        nnz_d   = nnz_q;
        col_d   = col_q;
        vr_d    = vr_q;
        vi_d    = vi_q;
        case (state_q)
            IDLE: begin
                if (bus.S_vld && s_rdy) begin
                    for (int unsigned k = 0; k < 4; k++) begin
                        col_d[k] = bus.Scol_index[k*IDXW +: IDXW];
                    end
                    vr_d    = {bus.S_val_r3, bus.S_val_r2, bus.S_val_r1, bus.S_val_r0};
                    vi_d    = {bus.S_val_i3, bus.S_val_i2, bus.S_val_i1, bus.S_val_i0};
                    nnz_d   = clamp_nnz(bus.S_nnz);
                    r_d     = '0;
                    k_d     = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.e_rdy) begin
                    if (last_row) begin
                        k_d = '0;
                        r_d = r_q + 1'b1;
                        if (last_mat) state_d = IDLE;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, all cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            r_q     <= '0;
            k_q     <= '0;
            nnz_q   <= '0;
            col_q   <= '0;
            vr_q    <= '0;
            vi_q    <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            r_q     <= r_d;
            k_q     <= k_d;
            nnz_q   <= nnz_d;
            col_q   <= col_d;
            vr_q    <= vr_d;
            vi_q    <= vi_d;
        end
    end
endmodule

// File: tb/tb_csc_rd.sv
// tb_csc_rd: table-driven bench for csc_rd at MAT_RANK=16, with directed
// sequences for reset behaviour and wrap/boundary spot values.
`timescale 1ns/1ps
module tb_csc_rd;
    localparam int unsigned MAT_RANK = 16;
    localparam int unsigned IDXW     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [3:0] seen [0:63];

    csc_rd_if #(.MAT_RANK(MAT_RANK)) bus ();
    csc_rd #(.MAT_RANK(MAT_RANK)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][3:0]  col;
        logic [3:0][31:0] vi;
        logic [2:0]       nnz_in;
        int unsigned      exp_nnz;
        bit               stall;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] c0, input logic [3:0] c1,
                                input logic [3:0] c2, input logic [3:0] c3,
                                input logic [2:0] nnz_in, input int unsigned exp_nnz,
                                input bit stall,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [31:0] i2, input logic [31:0] i3);
        vec_t v;
        v.col     = {c3, c2, c1, c0};
        v.vi      = {i3, i2, i1, i0};
        v.nnz_in  = nnz_in;
        v.exp_nnz = exp_nnz;
        v.stall   = stall;
        return v;
    endfunction

    function automatic logic [31:0] vr_of(input int unsigned vid, input int unsigned k);
        return 32'hA000_0000 + 32'(vid * 256 + k);
    endfunction

    function automatic logic [31:0] herm_neg(input logic [31:0] v);
        if (v == 32'h8000_0000) return 32'h7FFF_FFFF;
        return 32'd0 - v;
    endfunction

    function automatic logic [74:0] snap();
        return {bus.e_row, bus.e_col, bus.e_val_i, bus.e_val_r,
                bus.e_last_row, bus.e_last, bus.e_vld};
    endfunction

    // Sends one descriptor and consumes its elements; abort_at != 0 stops
    // consuming when element index abort_at is being presented.
    task automatic run_desc(input vec_t v, input int unsigned vid, input int unsigned abort_at);
        int unsigned n, total, idx, cyc, row, k;
        bit waited, held, rdy, elr, el;
        logic [74:0] hold_snap, cur;
        logic [3:0] scol, erow, ecol;
        logic [31:0] evi;
        n     = v.exp_nnz;
        total = n * MAT_RANK;
        @(negedge clk);
        bus.Scol_index = v.col;
        bus.S_val_i0 = v.vi[0];  bus.S_val_i1 = v.vi[1];
        bus.S_val_i2 = v.vi[2];  bus.S_val_i3 = v.vi[3];
        bus.S_val_r0 = vr_of(vid, 0); bus.S_val_r1 = vr_of(vid, 1);
        bus.S_val_r2 = vr_of(vid, 2); bus.S_val_r3 = vr_of(vid, 3);
        bus.S_nnz = v.nnz_in;
        bus.S_vld = 1'b1;
        waited = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.S_rdy === 1'b1) begin
                waited = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("s_rdy_wait_v%0d", vid), 128'(waited), 128'(1));
        if (!waited) begin
            bus.S_vld = 1'b0;
            return;
        end
        @(negedge clk);
        // keep offering a different descriptor throughout EMIT; it must be ignored
        bus.Scol_index = '1;
        bus.S_nnz      = 3'd3;
        bus.S_val_i0 = 32'hDEAD_0000; bus.S_val_i1 = 32'hDEAD_0001;
        bus.S_val_i2 = 32'hDEAD_0002; bus.S_val_i3 = 32'hDEAD_0003;
        bus.S_val_r0 = 32'hBEEF_0000; bus.S_val_r1 = 32'hBEEF_0001;
        bus.S_val_r2 = 32'hBEEF_0002; bus.S_val_r3 = 32'hBEEF_0003;
        chk($sformatf("first_vld_v%0d", vid), 128'(bus.e_vld), 128'(1));
        idx = 0; cyc = 0; held = 1'b0; hold_snap = '0;
        while (idx < total && cyc < total * 4 + 20) begin
            if (abort_at != 0 && idx == abort_at) break;
            cur = snap();
            if (held) chk($sformatf("stall_hold_v%0d_e%0d", vid, idx), 128'(cur), 128'(hold_snap));
            chk($sformatf("s_rdy_emit_v%0d", vid), 128'(bus.S_rdy), 128'(0));
            rdy = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.e_rdy = rdy;
            if (rdy) begin
                row  = idx / n;
                k    = idx % n;
                scol = v.col[k] + 4'(row);
                elr  = (k == n - 1);
                el   = elr && (row == MAT_RANK - 1);
`ifdef CSC_RD_HERM_EN
                erow = scol;     ecol = 4'(row); evi = herm_neg(v.vi[k]);
                seen[idx] = bus.e_row;
`else
                erow = 4'(row);  ecol = scol;    evi = v.vi[k];
                seen[idx] = bus.e_col;
`endif
                chk($sformatf("elem_v%0d_e%0d", vid, idx), 128'(cur),
                    128'({erow, ecol, evi, vr_of(vid, k), elr, el, 1'b1}));
                idx++;
            end
            held = !rdy;
            hold_snap = cur;
            @(negedge clk);
            cyc++;
        end
        if (abort_at != 0) return;
        chk($sformatf("elem_count_v%0d", vid), 128'(idx), 128'(total));
        if (!v.stall) chk($sformatf("cycles_v%0d", vid), 128'(cyc), 128'(total));
        chk($sformatf("done_vld_v%0d", vid), 128'(bus.e_vld), 128'(0));
        chk($sformatf("done_srdy_v%0d", vid), 128'(bus.S_rdy), 128'(1));
        bus.S_vld = 1'b0;
        bus.e_rdy = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_srdy"}, 128'(bus.S_rdy), 128'(0));
        chk({tag, "_evld"}, 128'(bus.e_vld), 128'(0));
        chk({tag, "_flags"}, 128'({bus.e_last_row, bus.e_last}), 128'(0));
        chk({tag, "_coord"}, 128'({bus.e_row, bus.e_col}), 128'(0));
        chk({tag, "_val"}, 128'({bus.e_val_i, bus.e_val_r}), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // columns, nnz in, expected nnz, stall, imag values k0..k3
        vecs[0] = mk(4'd0, 4'd4, 4'd8, 4'd12, 3'd4, 4, 1'b0,
                     32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678);
        vecs[1] = mk(4'd14, 4'd15, 4'd0, 4'd0, 3'd2, 2, 1'b0,
                     32'h0000_0010, 32'h8000_0001, 32'h0, 32'h0);
        vecs[2] = mk(4'd3, 4'd3, 4'd9, 4'd1, 3'd3, 3, 1'b1,
                     32'h7FFF_FFFF, 32'h0, 32'h5, 32'h6);
        vecs[3] = mk(4'd1, 4'd2, 4'd3, 4'd4, 3'd7, 4, 1'b0,
                     32'h11, 32'h22, 32'h33, 32'h44);
        vecs[4] = mk(4'd5, 4'd10, 4'd0, 4'd0, 3'd1, 2, 1'b0,
                     32'h55, 32'h66, 32'h77, 32'h88);
        vecs[5] = mk(4'd9, 4'd0, 4'd7, 4'd7, 3'd0, 2, 1'b1,
                     32'hCAFE_0000, 32'h1, 32'h2, 32'h3);
        vecs[6] = mk(4'd2, 4'd6, 4'd11, 4'd13, 3'd5, 4, 1'b1,
                     32'h0001_0000, 32'h1, 32'h8000_0000, 32'h0);

        bus.Scol_index = '0;
        bus.S_val_i0 = '0; bus.S_val_i1 = '0; bus.S_val_i2 = '0; bus.S_val_i3 = '0;
        bus.S_val_r0 = '0; bus.S_val_r1 = '0; bus.S_val_r2 = '0; bus.S_val_r3 = '0;
        bus.S_nnz = '0;
        bus.S_vld = 1'b0;
        bus.e_rdy = 1'b0;

        // reset state, then S_rdy only after the first edge past release
        @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("srdy_before_edge", 128'(bus.S_rdy), 128'(0));
        @(negedge clk);
        chk("srdy_after_edge", 128'(bus.S_rdy), 128'(1));

        for (int unsigned i = 0; i < 7; i++) begin
            run_desc(vecs[i], i, 0);
            if (i == 0) begin
                chk("r0_cols", 128'({seen[0], seen[1], seen[2], seen[3]}),
                    128'({4'd0, 4'd4, 4'd8, 4'd12}));
                chk("r15_cols", 128'({seen[60], seen[61], seen[62], seen[63]}),
                    128'({4'd15, 4'd3, 4'd7, 4'd11}));
            end
            if (i == 1) begin
                chk("r3_wrap_cols", 128'({seen[6], seen[7]}), 128'({4'd1, 4'd2}));
            end
        end

        // reset while element 20 is presented: abort at once, restart clean
        run_desc(vecs[0], 0, 19);
        chk("pre_abort_vld", 128'(bus.e_vld), 128'(1));
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("abort");
        bus.S_vld = 1'b0;
        bus.e_rdy = 1'b1;
        @(negedge clk);
        chk("abort_vld_held", 128'(bus.e_vld), 128'(0));
        rst_n = 1'b1;
        bus.e_rdy = 1'b0;
        @(negedge clk);
        chk("abort_srdy", 128'(bus.S_rdy), 128'(1));
        run_desc(vecs[1], 1, 0);
        chk("restart_r0_cols", 128'({seen[0], seen[1]}), 128'({4'd14, 4'd15}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csc_rd.md
CSC_RD -- requirements
Module: csc_rd

Interface
REQ-001 SHALL have parameter MAT_RANK, default 256, matrix dimension; power of two, >= 4.
REQ-002 SHALL derive local IDXW = $clog2(MAT_RANK), the index width.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port Scol_index, input, 4*IDXW, row-0 column of nonzero k in bits [k*IDXW +: IDXW], k=0..3.
REQ-006 SHALL have ports S_val_i0..S_val_i3 and S_val_r0..S_val_r3, input, 32 each, imaginary/real value of nonzero k.
REQ-007 SHALL have port S_nnz, input, 3, nonzeros per row; legal 2..4.
REQ-008 SHALL have port S_vld, input, 1, descriptor valid.
REQ-009 SHALL have port S_rdy, output, 1, descriptor accepted when S_vld & S_rdy.
REQ-010 SHALL have ports e_row and e_col, output, IDXW each, element coordinates.
REQ-011 SHALL have ports e_val_i and e_val_r, output, 32 each, element value.
REQ-012 SHALL have ports e_last_row and e_last, output, 1 each, last element of row / of matrix.
REQ-013 SHALL have port e_vld, output, 1, element valid.
REQ-014 SHALL have port e_rdy, input, 1, downstream ready.

Function
REQ-015 SHALL implement FSM IDLE -> EMIT -> IDLE; S_rdy = 1 only in IDLE.
REQ-016 SHALL, on S_vld & S_rdy in IDLE, register all descriptor fields, clear row counter r and slot counter k, and enter EMIT next cycle.
REQ-017 SHALL clamp S_nnz at capture: values 0..1 become 2, values 5..7 become 4.
REQ-018 SHALL, in EMIT, hold e_vld = 1 and present e_row = r, e_col = (Scol_index[k] + r) mod MAT_RANK using natural IDXW-bit wrap, e_val = captured value k.
REQ-019 SHALL advance only on e_vld & e_rdy: k increments; at k = nnz-1, k -> 0 and r increments.
REQ-020 SHALL hold all e_* outputs stable while e_vld & !e_rdy.
REQ-021 SHALL assert e_last_row when k = nnz-1, and e_last when additionally r = MAT_RANK-1.
REQ-022 SHALL, on acceptance of the e_last element, return to IDLE; e_vld = 0 and S_rdy = 1 in the following cycle.
REQ-023 SHALL sustain one element per cycle with e_rdy held high; first e_vld one cycle after descriptor handshake.
REQ-024 SHALL emit exactly nnz*MAT_RANK elements per descriptor, in row-major order with k ascending inside a row.
REQ-025 SHALL ignore S_vld while in EMIT; a new descriptor is never captured before e_last is accepted.
REQ-026 SHALL emit duplicate columns unchanged when two Scol_index fields are equal; no merging.

Reset
REQ-027 SHALL, while rst_n = 0, force IDLE, S_rdy = 0, e_vld = 0, e_last_row = 0, e_last = 0, and zero e_row, e_col, e_val_i, e_val_r and all counters and registers.
REQ-028 SHALL drive S_rdy = 1 from the first clock edge after rst_n deasserts.
REQ-029 SHALL, on reset asserted mid-EMIT, abort the matrix immediately with no further elements emitted.

Configuration
REQ-030 SHALL support macro CSC_RD_HERM_EN.
REQ-031 With CSC_RD_HERM_EN defined, SHALL emit the Hermitian transpose: e_row and e_col swapped, e_val_i = two's-complement negation of the stored imaginary value, with 0x80000000 saturating to 0x7FFFFFFF; order, counts and flags remain per REQ-021..REQ-024.
REQ-032 Without CSC_RD_HERM_EN, SHALL emit S itself per REQ-018.

Verification
REQ-033 MAT_RANK=16, Scol={0,4,8,12}, nnz=4, e_rdy=1 -> 64 elements on consecutive cycles; row 0 cols 0,4,8,12; row 15 cols 15,3,7,11; e_last on element 64.
REQ-034 MAT_RANK=16, Scol k0=14, k1=15, nnz=2 -> row 3 emits cols 1,2 (wrap); 32 elements total.
REQ-035 Random e_rdy stall pattern -> outputs stable while stalled; sequence identical to unstalled run; S_rdy=0 throughout EMIT.
REQ-036 S_nnz=7 and S_nnz=1 -> 4 and 2 elements per row respectively.
REQ-037 rst_n pulsed low at element 20 -> e_vld=0 immediately; S_rdy=1 after release; next descriptor emitted from row 0.
REQ-038 CSC_RD_HERM_EN defined, S_val_i0=0x00010000 at Scol k0=2 -> first element e_row=2, e_col=0, e_val_i=0xFFFF0000.
